gd_pdm_capture: RTL
===================

# gd_pdm_capture

Stereo PDM audio capture: the input-direction counterpart of the on-chip audio DAC path. Drives a PDM clock to one or two external 1-bit microphones sharing a data line. Decimates the left and right bitstreams through a 3rd-order CIC filter into signed 16-bit PCM samples. Samples are presented with a one-cycle strobe at the audio frame rate, in the same `sample_l`/`sample_r` format the playback path consumes.

## Interface
Parameters:
- `CLK_DIV`, 16: `vga_clk` cycles per PDM clock period; power of two, ≥ 4.
- `DECIM`, 64: PDM clocks per output sample; fixed at 64 for the `ACC_W`/shift rules below.

Ports:
- `vga_clk`  in  1  sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  capture enable; low holds the block idle and clears the filter state.
- `pdm_data_in`  in  1  shared microphone data pin; asynchronous.
- `pdm_clk`  out  1  microphone clock, registered.
- `sample_l`  out  16  signed left PCM sample.
- `sample_r`  out  16  signed right PCM sample.
- `sample_strobe`  out  1  one-cycle pulse when `sample_l`/`sample_r` update.

## Operation
- **Input sync:** `pdm_data_in` passes through a 2-flop synchroniser before use.
- **Clock divider:** `div_cnt` counts 0..CLK_DIV-1 and wraps. `pdm_clk` is registered and equals `div_cnt` ≥ CLK_DIV/2, so it is low for the first half of the period.
- **Channel capture:**
  - Left is captured on the cycle where `div_cnt == CLK_DIV-1` (end of the high phase).
  - Right is captured on the cycle where `div_cnt == CLK_DIV/2-1` (end of the low phase).
- **Input mapping:** a captured 1 maps to +1 and a 0 maps to -1 (2-bit signed).
- **Per-channel CIC (order 3):**
  - Three cascaded integrators update only on that channel's capture cycle.
  - Three combs with differential delay 1 run at the decimated rate.
- **Arithmetic:** all integrator and comb registers are `ACC_W`=20 bits, two's complement, with wrap-around. Overflow is intentional and must not be saturated.
- **Decimation:** `dec_cnt` counts left captures 0..DECIM-1. The decimation tick is the right-capture cycle that follows the left capture where `dec_cnt` is DECIM-1. On the tick, both channels' comb chains sample their integrator-3 outputs.
- **Output scaling:** CIC gain is 64³ = 2^18, so the comb output y lies in [-2^18, 2^18]. Output = saturate16(y >>> 3), i.e. 32768 clamps to 32767 and the floor is -32768.
- **Enable low:** `div_cnt`, `dec_cnt`, `pdm_clk`, integrators, comb delays and `sample_strobe` are all held at 0. `sample_l`/`sample_r` keep their last values.
- **Settling:** the first 3 strobes after reset or after `enable` rises are filter transient. They are still strobed, and consumers discard them.

## Timing
- **Reset values:** `pdm_clk`=0, `sample_l`=0, `sample_r`=0, `sample_strobe`=0, and all counters and filter registers 0.
- **Reset mid-frame:** reset takes effect on the next edge with no partial strobe.
- **Strobe period:** `sample_strobe` repeats every CLK_DIV×DECIM `vga_clk` cycles (1024 at defaults).
- **Pipeline from tick cycle T:**
  - T: integrators update.
  - T+1: comb outputs are registered.
  - T+2: saturated samples are registered, and `sample_strobe` is high for exactly that one cycle.
- **Input latency:** the captured bit is the pin value from 2 cycles before the capture cycle (synchroniser depth).
- **Enable edge:** `enable` rising restarts `div_cnt`/`dec_cnt` from 0 on the following cycle. A tick in progress when `enable` falls produces no strobe.
- **Sample hold:** outputs are stable between strobes. There is no backpressure, so consumers must sample on the strobe.

## Structure
- **Package `gd_audio_pkg`:** `CIC_ORDER`=3, `ACC_W`=20, `SAMPLE_W`=16, `OUT_SHIFT`=3, and the saturate16 function.
- **Sub-module `gd_cic3_decim`:** one channel's integrators, combs and saturation. It has inputs `bit_in`, `in_en`, `dec_tick`, `clr` and output `sample`. It is instantiated twice.
- **Top level:** holds the synchroniser, divider, capture decode, `dec_cnt` and the strobe pipeline.

## Test plan
- **Constant high:** pin held 1, enable after reset → `pdm_clk` period 16 cycles; from strobe 4 on, `sample_l`=`sample_r`=32767.
- **Constant low:** pin held 0 → from strobe 4 on, `sample_l`=`sample_r`=-32768; strobes spaced exactly 1024 cycles.
- **Alternating bits:** left bit toggles each left capture, right held 1 → `sample_l`=0 and `sample_r`=32767 after settling.
- **Channel separation:** pin = `pdm_clk` (1 at left captures, 0 at right captures) → `sample_l`=32767 and `sample_r`=-32768, confirming no cross-talk.
- **Reset mid-frame:** `reset` pulsed 500 cycles into a frame → next edge shows all outputs and counters at 0; next strobe arrives at 1024+2 cycles after reset release, relative to the tick.
- **Enable toggle:** `enable` dropped for 100 cycles → `pdm_clk` held 0, no strobes, samples hold their last value; after re-enable, 3 transient strobes, then steady values resume.

Source files
------------

// File: rtl/gd_audio_pkg.sv
// Shared audio-path constants and the PCM saturation helper.
package gd_audio_pkg;
  localparam int CIC_ORDER = 3;
  localparam int ACC_W     = 20;
  localparam int SAMPLE_W  = 16;
  localparam int OUT_SHIFT = 3;
  localparam int NUM_CH    = 2;   // 0 = left, 1 = right

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((1 << (SAMPLE_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(1 << (SAMPLE_W-1)));

  // Clamp a scaled filter output into the signed 16-bit PCM range.
  function automatic logic signed [SAMPLE_W-1:0] saturate16(input logic signed [ACC_W-1:0] v);
    if (v > SAT_HI)      return SAT_HI[SAMPLE_W-1:0];
    else if (v < SAT_LO) return SAT_LO[SAMPLE_W-1:0];
    else                 return v[SAMPLE_W-1:0];
  endfunction
endpackage

// File: rtl/gd_cic3_decim.sv
// One channel of the CIC decimator: integrators at the PDM rate, combs and
// saturation at the decimated rate. Registers wrap modulo 2^ACC_W by design.
module gd_cic3_decim
  import gd_audio_pkg::*;
(
  input  logic                       vga_clk,
  input  logic                       reset,
  input  logic                       bit_in,
  input  logic                       in_en,
  input  logic                       dec_tick,
  input  logic                       clr,
  output logic signed [SAMPLE_W-1:0] sample
);
  logic [CIC_ORDER-1:0][ACC_W-1:0] integ;
  logic [CIC_ORDER-1:0][ACC_W-1:0] dly;
  logic [CIC_ORDER:0][ACC_W-1:0]   cstage;
  logic [ACC_W-1:0]                x;
  logic [ACC_W-1:0]                y;
  logic signed [ACC_W-1:0]         y_sh;
  logic                            tick_d1;

  // 1 -> +1, 0 -> -1, sign-extended to the accumulator width
  assign x    = {{(ACC_W-1){~bit_in}}, 1'b1};
  assign y_sh = $signed(y) >>> OUT_SHIFT;

  // Integrator cascade, advancing only on this channel's capture cycle
  always_ff @(posedge vga_clk) begin
    if (reset || clr) begin
      integ <= '0;
    end else if (in_en) begin
      integ[0] <= integ[0] + x;
      for (int i = 1; i < CIC_ORDER; i++)
        integ[i] <= integ[i] + integ[i-1];
    end
  end

  // Comb chain, differential delay 1, fed from the last integrator
  always_comb begin
    cstage    = '0;
    cstage[0] = integ[CIC_ORDER-1];
    for (int i = 0; i < CIC_ORDER; i++)
      cstage[i+1] = cstage[i] - dly[i];
  end

  // Comb delays and comb output register, updated on the decimation tick
  always_ff @(posedge vga_clk) begin
    if (reset || clr) begin
      dly     <= '0;
      y       <= '0;
      tick_d1 <= 1'b0;
    end else begin
      tick_d1 <= dec_tick;
      if (dec_tick) begin
        for (int i = 0; i < CIC_ORDER; i++)
          dly[i] <= cstage[i];
        y <= cstage[CIC_ORDER];
      end
    end
  end

  // Scaled, saturated sample; holds across enable-low
  always_ff @(posedge vga_clk) begin
    if (reset)        sample <= '0;
    else if (tick_d1 && !clr) sample <= saturate16(y_sh);
  end
endmodule

// File: rtl/gd_pdm_capture.sv
// Stereo PDM microphone capture: clock generation, L/R capture on opposite
// phases of pdm_clk, CIC decimation to 16-bit PCM with a frame strobe.
module gd_pdm_capture
  import gd_audio_pkg::*;
#(
  parameter int CLK_DIV = 16,
  parameter int DECIM   = 64
) (
  input  logic                       vga_clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       pdm_data_in,
  output logic                       pdm_clk,
  output logic signed [SAMPLE_W-1:0] sample_l,
  output logic signed [SAMPLE_W-1:0] sample_r,
  output logic                       sample_strobe
);
  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int DEC_W  = $clog2(DECIM);
  localparam int STAGES = 2;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [DIV_W-1:0] DIV_MID  = DIV_W'(CLK_DIV / 2 - 1);
  localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECIM - 1);

  logic [1:0]                          pdm_sync;
  logic [DIV_W-1:0]                    div_cnt, div_nxt;
  logic [DEC_W-1:0]                    dec_cnt;
  logic                                tick_pend;
  logic                                dec_tick;
  logic [NUM_CH-1:0]                   cap;
  logic [STAGES:1]                     vld_pipe;
  logic [NUM_CH-1:0][SAMPLE_W-1:0]     samples;

  assign div_nxt  = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
  assign cap[0]   = enable && (div_cnt == DIV_LAST);  // end of high phase
  assign cap[1]   = enable && (div_cnt == DIV_MID);   // end of low phase
  assign dec_tick = cap[1] && tick_pend;

  // Two-flop synchroniser for the asynchronous microphone pin
  always_ff @(posedge vga_clk) begin
    if (reset) pdm_sync <= '0;
    else       pdm_sync <= {pdm_sync[0], pdm_data_in};
  end

  // Clock divider; pdm_clk is low for the first half of each period
  always_ff @(posedge vga_clk) begin
    if (reset || !enable) begin
      div_cnt <= '0;
      pdm_clk <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      pdm_clk <= (div_nxt >= DIV_HALF);
    end
  end

  // Left-capture count; the tick fires on the right capture after the last left
  always_ff @(posedge vga_clk) begin
    if (reset || !enable) begin
      dec_cnt   <= '0;
      tick_pend <= 1'b0;
    end else begin
      if (cap[0]) begin
        dec_cnt <= (dec_cnt == DEC_LAST) ? '0 : dec_cnt + 1'b1;
        if (dec_cnt == DEC_LAST) tick_pend <= 1'b1;
      end
      if (dec_tick) tick_pend <= 1'b0;
    end
  end

  // Strobe pipeline matching the comb and saturation register stages
  always_ff @(posedge vga_clk) begin
    if (reset || !enable) vld_pipe <= '0;
    else                  vld_pipe <= {vld_pipe[STAGES-1:1], dec_tick};
  end

  assign sample_strobe = vld_pipe[STAGES];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    gd_cic3_decim u_cic (
      .vga_clk  (vga_clk),
      .reset    (reset),
      .bit_in   (pdm_sync[1]),
      .in_en    (cap[c]),
      .dec_tick (dec_tick),
      .clr      (~enable),
      .sample   (samples[c])
    );
  end

  assign sample_l = samples[0];
  assign sample_r = samples[1];
endmodule
